// File: rtl/move_scheduler.sv
// move_scheduler: steps a block position every STEP_DIV+2 clocks along the latest requested heading.
// Optional feature macro NO_REVERSE_EN: a request opposite the current heading is dropped at sampling.
module move_scheduler #(
   parameter int unsigned STEP_DIV = 833333,
   parameter int unsigned STEP     = 2,
   parameter int unsigned X_MIN    = 150,
   parameter int unsigned X_MAX    = 800,
   parameter int unsigned Y_MIN    = 34,
   parameter int unsigned Y_MAX    = 514
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic [1:0] direction,
   output logic       step_pulse,
   output logic       wrapped
);

   localparam int unsigned      DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [10:0]      STEP_W   = 11'(STEP);
   localparam logic [10:0]      X_MIN_W  = 11'(X_MIN);
   localparam logic [10:0]      X_MAX_W  = 11'(X_MAX);
   localparam logic [10:0]      Y_MIN_W  = 11'(Y_MIN);
   localparam logic [10:0]      Y_MAX_W  = 11'(Y_MAX);
   localparam logic [9:0]       X_RST    = 10'd450;
   localparam logic [9:0]       Y_RST    = 10'd250;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_LEFT  = 2'b01,
      DIR_UP    = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      MOVE
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             pend_valid_q, pend_valid_d;
   dir_t             pend_dir_q, pend_dir_d;
   dir_t             dir_q, dir_d;
   logic [9:0]       xpos_q, xpos_d;
   logic [9:0]       ypos_q, ypos_d;
   logic             pulse_q, pulse_d;
   logic             wrap_q, wrap_d;

   logic             btn_any;
   dir_t             btn_dir;
   logic             reverse;
   logic [9:0]       mv_x, mv_y;
   logic             mv_wrap;

   always_comb begin
      btn_any = right | left | up | down;
      btn_dir = DIR_DOWN;
      if (right)     btn_dir = DIR_RIGHT;
      else if (left) btn_dir = DIR_LEFT;
      else if (up)   btn_dir = DIR_UP;
   end

`ifdef NO_REVERSE_EN
   always_comb reverse = (pend_dir_q == (dir_q ^ 2'b01));
`else
   always_comb reverse = 1'b0;
`endif

   // Widened to 11 bits so position +/- STEP cannot overflow before the bound test.
   always_comb begin
      mv_x    = xpos_q;
      mv_y    = ypos_q;
      mv_wrap = 1'b0;
      case (dir_q)
         DIR_RIGHT: begin
            if (({1'b0, xpos_q} + STEP_W) > X_MAX_W) begin
               mv_x    = X_MIN_W[9:0];
               mv_wrap = 1'b1;
            end else begin
               mv_x = 10'({1'b0, xpos_q} + STEP_W);
            end
         end
         DIR_LEFT: begin
            if ({1'b0, xpos_q} < (X_MIN_W + STEP_W)) begin
               mv_x    = X_MAX_W[9:0];
               mv_wrap = 1'b1;
            end else begin
               mv_x = 10'({1'b0, xpos_q} - STEP_W);
            end
         end
         DIR_UP: begin
            if ({1'b0, ypos_q} < (Y_MIN_W + STEP_W)) begin
               mv_y    = Y_MAX_W[9:0];
               mv_wrap = 1'b1;
            end else begin
               mv_y = 10'({1'b0, ypos_q} - STEP_W);
            end
         end
         DIR_DOWN: begin
            if (({1'b0, ypos_q} + STEP_W) > Y_MAX_W) begin
               mv_y    = Y_MIN_W[9:0];
               mv_wrap = 1'b1;
            end else begin
               mv_y = 10'({1'b0, ypos_q} + STEP_W);
            end
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      pend_valid_d = pend_valid_q;
      pend_dir_d   = pend_dir_q;
      dir_d        = dir_q;
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      pulse_d      = 1'b0;
      wrap_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = SAMPLE;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         SAMPLE: begin
            if (pend_valid_q) begin
               if (!reverse) dir_d = pend_dir_q;
               pend_valid_d = 1'b0;
            end
            state_d = MOVE;
         end
         MOVE: begin
            xpos_d  = mv_x;
            ypos_d  = mv_y;
            pulse_d = 1'b1;
            wrap_d  = mv_wrap;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Applied after the state case so a press during SAMPLE survives the clear.
      if (btn_any) begin
         pend_valid_d = 1'b1;
         pend_dir_d   = btn_dir;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         div_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_dir_q   <= DIR_RIGHT;
         dir_q        <= DIR_RIGHT;
         xpos_q       <= X_RST;
         ypos_q       <= Y_RST;
         pulse_q      <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         pend_valid_q <= pend_valid_d;
         pend_dir_q   <= pend_dir_d;
         dir_q        <= dir_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         pulse_q      <= pulse_d;
         wrap_q       <= wrap_d;
      end
   end

   assign xpos       = xpos_q;
   assign ypos       = ypos_q;
   assign direction  = dir_q;
   assign step_pulse = pulse_q;
   assign wrapped    = wrap_q;

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter STEP_DIV, default 833333: clk cycles per movement step.
REQ-002 Parameter STEP, default 2: pixels moved per step.
REQ-003 Parameters X_MIN/X_MAX, defaults 150/800: horizontal wrap bounds in hCount units.
REQ-004 Parameters Y_MIN/Y_MAX, defaults 34/514: vertical wrap bounds in vCount units.
REQ-005 Port clk, input, 1: single system clock; all state SHALL be clocked on its rising edge.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Ports up, down, left, right, input, 1 each: synchronized, debounced button levels.
REQ-008 Port xpos, output, 10: registered block-centre horizontal position.
REQ-009 Port ypos, output, 10: registered block-centre vertical position.
REQ-010 Port direction, output, 2: current heading; 00 right, 01 left, 10 up, 11 down.
REQ-011 Port step_pulse, output, 1: one-cycle pulse on every position update.
REQ-012 Port wrapped, output, 1: one-cycle pulse, coincident with step_pulse, when the update wrapped.

Function
REQ-013 The block SHALL run a three-state FSM: IDLE, SAMPLE and MOVE.
REQ-014 In IDLE, a divider SHALL count from 0 to STEP_DIV-1 and then move to SAMPLE with the divider cleared.
REQ-015 Any cycle with a button high SHALL load a pending request using the priority right > left > up > down, overwriting any older request.
REQ-016 In SAMPLE, a valid pending request SHALL load direction and clear pending, and the FSM SHALL then move to MOVE.
REQ-017 A button press in the same cycle as SAMPLE SHALL be held pending for the next step.
REQ-018 In MOVE, position SHALL update per direction, step_pulse SHALL assert for that single cycle, and the FSM SHALL return to IDLE.
REQ-019 Step latency from divider terminal count to the new xpos/ypos SHALL be 2 cycles; the step period SHALL be STEP_DIV+2 cycles.
REQ-020 Right: if xpos+STEP > X_MAX, xpos SHALL become X_MIN with wrapped=1; otherwise xpos SHALL become xpos+STEP.
REQ-021 Left: if xpos < X_MIN+STEP, xpos SHALL become X_MAX with wrapped=1; otherwise xpos SHALL become xpos-STEP.
REQ-022 Up and down SHALL apply the same rules to ypos using Y_MIN and Y_MAX.
REQ-023 Comparisons SHALL use 11-bit arithmetic so the 10-bit positions never overflow.
REQ-024 Only the moving axis SHALL change on a step; the other axis SHALL hold its value.

Reset
REQ-025 While rst is high, the outputs SHALL be xpos=450, ypos=250, direction=00, step_pulse=0 and wrapped=0.
REQ-026 While rst is high, the internal state SHALL be FSM=IDLE, divider=0 and pending=invalid.
REQ-027 Reset asserted mid-step (SAMPLE or MOVE) SHALL abort the step with no pulse and no position change beyond the reset values.

Configuration
REQ-028 With NO_REVERSE_EN defined, a pending request opposite to the current direction SHALL be discarded in SAMPLE, and direction SHALL be unchanged.
REQ-029 Without NO_REVERSE_EN, every pending request SHALL be accepted in SAMPLE, including a reversal.

Verification
REQ-030 STEP_DIV=4, reset, no buttons -> step_pulse every 6 cycles, with xpos 452, 454, 456 and ypos fixed at 250.
REQ-031 xpos=800 heading right, at step -> xpos=150, wrapped=1 and step_pulse=1 in the same cycle.
REQ-032 ypos=35 heading up (STEP=2), at step -> ypos=514 and wrapped=1.
REQ-033 up and left pulsed together in IDLE -> direction=01 at the next SAMPLE, and the up request is lost.
REQ-034 Heading right, left pulsed -> with NO_REVERSE_EN, direction stays 00 and xpos keeps increasing; without it, direction=01 and xpos decreases.
REQ-035 rst asserted during MOVE -> xpos=450 and ypos=250 immediately, no step_pulse, and the first pulse comes STEP_DIV+2 cycles after release.
